// File: rtl/conv_channel_seq.sv
`default_nettype none
// =============================================================================
// Module      : conv_channel_seq
// Description : Multi-channel sequencer for a single conv_standard engine.
//               It accepts NCH (5x5 map, 3x3 weight) pairs, fires the engine
//               once per pair and sums the 3x3 results into wide accumulators.
//               Optional build macro: CONV_SEQ_RELU_EN (clamps final sums >= 0).
// Revision    : 1.0 - initial release
// =============================================================================
module conv_channel_seq #(
    parameter int NBITS = 16,
    parameter int NCH   = 3,
    parameter int ACCW  = NBITS + 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  map_valid,
    output logic                  map_ready,
    input  logic [25*NBITS-1:0]   map_in,
    input  logic [9*NBITS-1:0]    w_in,
    output logic                  conv_start,
    output logic [25*NBITS-1:0]   conv_inputMAP,
    output logic [9*NBITS-1:0]    conv_weights,
    input  logic [9*NBITS-1:0]    conv_outputMAP,
    input  logic                  conv_data_valid,
    output logic [9*ACCW-1:0]     out_map,
    output logic                  out_valid,
    output logic                  busy,
    output logic [7:0]            chan_idx
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FIRE = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_CHAN = 8'(NCH - 1);

    state_t               state_q, state_d;
    logic [7:0]           chan_idx_q, chan_idx_d;
    logic [ACCW-1:0]      acc_q [9];
    logic [ACCW-1:0]      acc_d [9];
    logic [ACCW-1:0]      acc_sum [9];
    logic [25*NBITS-1:0]  imap_q, imap_d;
    logic [9*NBITS-1:0]   wts_q, wts_d;
    logic [9*ACCW-1:0]    out_map_q, out_map_d;

    function automatic logic [ACCW-1:0] finalize(input logic [ACCW-1:0] v);
`ifdef CONV_SEQ_RELU_EN
        finalize = v[ACCW-1] ? '0 : v;
`else
        finalize = v;
`endif
    endfunction

    // Engine results are sign-extended, sums wrap modulo 2^ACCW.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            acc_sum[i] = acc_q[i] + ACCW'($signed(conv_outputMAP[i*NBITS +: NBITS]));
        end
    end

    always_comb begin
        state_d    = state_q;
        chan_idx_d = chan_idx_q;
        acc_d      = acc_q;
        imap_d     = imap_q;
        wts_d      = wts_q;
        out_map_d  = out_map_q;
        map_ready  = 1'b0;
        conv_start = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < 9; i++) begin
                        acc_d[i] = '0;
                    end
                    chan_idx_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                map_ready = 1'b1;
                if (map_valid) begin
                    imap_d  = map_in;
                    wts_d   = w_in;
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                conv_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (conv_data_valid) begin
                    acc_d = acc_sum;
                    if (chan_idx_q == LAST_CHAN) begin
                        // Result is captured on the way into DONE so it is
                        // already visible while out_valid is high.
                        for (int i = 0; i < 9; i++) begin
                            out_map_d[i*ACCW +: ACCW] = finalize(acc_sum[i]);
                        end
                        state_d = S_DONE;
                    end else begin
                        chan_idx_d = chan_idx_q + 8'd1;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            chan_idx_q <= '0;
            imap_q     <= '0;
            wts_q      <= '0;
            out_map_q  <= '0;
            for (int i = 0; i < 9; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            chan_idx_q <= chan_idx_d;
            imap_q     <= imap_d;
            wts_q      <= wts_d;
            out_map_q  <= out_map_d;
            for (int i = 0; i < 9; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign conv_inputMAP = imap_q;
    assign conv_weights  = wts_q;
    assign out_map       = out_map_q;
    assign busy          = (state_q != S_IDLE);
    assign chan_idx      = chan_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_channel_seq.sv
`default_nettype none
// Testbench for conv_channel_seq: randomized jobs against a behavioural
// convolution/accumulation model with a queue-based output scoreboard.
module tb_conv_channel_seq;

    localparam int NB   = 8;
    localparam int NCHT = 3;
    localparam int AW   = NB + 8;

    typedef logic [25*NB-1:0] map_t;
    typedef logic [9*NB-1:0]  wts_t;
    typedef logic [9*AW-1:0]  res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, map_valid, map_ready, conv_start, out_valid, busy;
    logic        eng_dv, spur_dv, conv_data_valid;
    logic [7:0]  chan_idx;
    map_t        map_in, conv_inputMAP;
    wts_t        w_in, conv_weights, conv_outputMAP;
    res_t        out_map;

    assign conv_data_valid = eng_dv | spur_dv;

    conv_channel_seq #(.NBITS(NB), .NCH(NCHT), .ACCW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .map_valid(map_valid), .map_ready(map_ready),
        .map_in(map_in), .w_in(w_in),
        .conv_start(conv_start), .conv_inputMAP(conv_inputMAP),
        .conv_weights(conv_weights), .conv_outputMAP(conv_outputMAP),
        .conv_data_valid(conv_data_valid),
        .out_map(out_map), .out_valid(out_valid), .busy(busy), .chan_idx(chan_idx)
    );

    // Second instance: accumulator as narrow as the engine, two channels.
    logic        start_w, mv_w, ready_w, cs_w, dv_w, ov_w, busy_w;
    logic [7:0]  ci_w;
    map_t        imap_w;
    wts_t        wts_w, omap_w;
    logic [9*NB-1:0] out_w;

    conv_channel_seq #(.NBITS(NB), .NCH(2), .ACCW(NB)) dut_w (
        .clk(clk), .reset(reset), .start(start_w),
        .map_valid(mv_w), .map_ready(ready_w),
        .map_in('0), .w_in('0),
        .conv_start(cs_w), .conv_inputMAP(imap_w),
        .conv_weights(wts_w), .conv_outputMAP(omap_w),
        .conv_data_valid(dv_w),
        .out_map(out_w), .out_valid(ov_w), .busy(busy_w), .chan_idx(ci_w)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    int   cs_cnt   = 0;
    int   ov_cnt   = 0;
    int   eng_lat  = 4;
    res_t sb  [$];
    logic [9*NB-1:0] sbw [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 3x3 valid convolution of a 5x5 map, each output truncated to NB bits.
    function automatic wts_t engine_conv(input map_t m, input wts_t w);
        wts_t r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            int s;
            s = 0;
            for (int a = 0; a < 3; a++) begin
                for (int b = 0; b < 3; b++) begin
                    s += int'($signed(m[((i/3 + a)*5 + (i%3) + b)*NB +: NB]))
                       * int'($signed(w[(a*3 + b)*NB +: NB]));
                end
            end
            r[i*NB +: NB] = s[NB-1:0];
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] relu_w(input logic [AW-1:0] t);
`ifdef CONV_SEQ_RELU_EN
        return t[AW-1] ? '0 : t;
`else
        return t;
`endif
    endfunction

    function automatic res_t ref_job(input map_t ms [NCHT], input wts_t ws [NCHT]);
        int   acc [9];
        wts_t r;
        res_t e;
        for (int i = 0; i < 9; i++) acc[i] = 0;
        for (int c = 0; c < NCHT; c++) begin
            r = engine_conv(ms[c], ws[c]);
            for (int i = 0; i < 9; i++) acc[i] += int'($signed(r[i*NB +: NB]));
        end
        for (int i = 0; i < 9; i++) e[i*AW +: AW] = relu_w(acc[i][AW-1:0]);
        return e;
    endfunction

    // Engine model: result appears eng_lat cycles after the start pulse.
    initial begin
        int   cnt;
        wts_t res;
        cnt = 0;
        res = '0;
        eng_dv = 1'b0;
        conv_outputMAP = '0;
        forever begin
            @(negedge clk);
            eng_dv = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (conv_start) begin
                cnt = eng_lat;
                res = engine_conv(conv_inputMAP, conv_weights);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_dv = 1'b1;
                    conv_outputMAP = res;
                end
            end
        end
    end

    initial begin
        logic pend;
        pend = 1'b0;
        dv_w = 1'b0;
        omap_w = '0;
        forever begin
            @(negedge clk);
            dv_w = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else if (cs_w) begin
                pend = 1'b1;
            end else if (pend) begin
                pend   = 1'b0;
                dv_w   = 1'b1;
                omap_w = {9{8'h7F}};
            end
        end
    end

    // Output monitors / scoreboards.
    initial begin
        res_t e;
        logic [9*NB-1:0] ew;
        forever begin
            @(negedge clk);
            if (conv_start) cs_cnt++;
            if (out_valid) begin
                ov_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_out_valid: got out_map=%h expected no output", out_map);
                end else begin
                    e = sb.pop_front();
                    chk("out_map", out_map, e);
                end
            end
            if (ov_w) begin
                if (sbw.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_out_valid_w: got out_map=%h expected no output", out_w);
                end else begin
                    ew = sbw.pop_front();
                    chk("wrap_out_map", out_w, ew);
                end
            end
        end
    end

    task automatic send_pair(input map_t m, input wts_t w, input int gap, input bit chk_bp);
        int budget;
        budget = 0;
        map_valid = 1'b0;
        while (!map_ready && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (!map_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL map_ready_timeout: got 0 expected 1");
            return;
        end
        for (int k = 0; k < gap; k++) begin
            if (chk_bp) begin
                chk("bp_map_ready", map_ready, 1);
                chk("bp_no_conv_start", conv_start, 0);
            end
            @(negedge clk);
        end
        map_in    = m;
        w_in      = w;
        map_valid = 1'b1;
        @(negedge clk);
        map_valid = 1'b0;
    endtask

    task automatic run_job(input map_t ms [NCHT], input wts_t ws [NCHT], input int gap1, input bit bp);
        sb.push_back(ref_job(ms, ws));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int c = 0; c < NCHT; c++) begin
            send_pair(ms[c], ws[c], (c == 1) ? gap1 : 0, bp && (c == 1));
        end
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while ((busy || sb.size() != 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (busy || sb.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL job_timeout: got busy=%0d pending=%0d expected 0 0", busy, sb.size());
            sb.delete();
        end
    endtask

    map_t ms [NCHT];
    wts_t ws [NCHT];

    task automatic fill(input logic [NB-1:0] mv, input logic [NB-1:0] wv);
        for (int c = 0; c < NCHT; c++) begin
            ms[c] = {25{mv}};
            ws[c] = {9{wv}};
        end
    endtask

    initial begin
        int cs0, ov0, budget;
        logic [NB-1:0] wexp;
        int wsum;
        reset = 1'b1; start = 1'b0; map_valid = 1'b0; spur_dv = 1'b0;
        map_in = '0; w_in = '0; start_w = 1'b0; mv_w = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_map_ready", map_ready, 0);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_chan_idx", chan_idx, 0);
        chk("rst_out_map", out_map, 0);
        chk("rst_inputMAP", conv_inputMAP, 0);
        chk("rst_weights", conv_weights, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic sum: all ones -> 27 per element.
        fill(8'd1, 8'd1);
        eng_lat = 4;
        cs0 = cs_cnt; ov0 = ov_cnt;
        run_job(ms, ws, 0, 1'b0);
        wait_done();
        chk("basic_conv_starts", cs_cnt - cs0, 3);
        chk("basic_out_valids", ov_cnt - ov0, 1);

        // Negative sum: maps of -1.
        fill(8'hFF, 8'd1);
        run_job(ms, ws, 0, 1'b0);
        wait_done();

        // Backpressure before channel 1.
        fill(8'd1, 8'd1);
        run_job(ms, ws, 5, 1'b1);
        wait_done();

        // Spurious start in WAIT and spurious data_valid in LOAD.
        ov0 = ov_cnt;
        fork
            run_job(ms, ws, 0, 1'b0);
            begin
                budget = 0;
                while (!conv_start && budget < 200) begin @(negedge clk); budget++; end
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                budget = 0;
                while (!map_ready && budget < 200) begin @(negedge clk); budget++; end
                spur_dv = 1'b1;
                @(negedge clk);
                spur_dv = 1'b0;
            end
        join
        wait_done();
        repeat (3) @(negedge clk);
        chk("spur_no_new_job", busy, 0);
        chk("spur_out_valids", ov_cnt - ov0, 1);

        // Abort during WAIT of channel 1.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_pair(ms[0], ws[0], 0, 1'b0);
        send_pair(ms[1], ws[1], 0, 1'b0);
        @(negedge clk);
        chk("abort_pre_chan_idx", chan_idx, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_out_map", out_map, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_job(ms, ws, 0, 1'b0);
        wait_done();

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            for (int c = 0; c < NCHT; c++) begin
                for (int k = 0; k < 25; k++) ms[c][k*NB +: NB] = 8'($urandom);
                for (int k = 0; k < 9; k++)  ws[c][k*NB +: NB] = 8'($urandom);
            end
            eng_lat = int'($urandom_range(1, 6));
            run_job(ms, ws, int'($urandom_range(0, 3)), 1'b0);
            wait_done();
        end

        // Wrap: two channels of 127 into an 8-bit accumulator.
        wsum = 2 * 127;
        wexp = wsum[NB-1:0];
`ifdef CONV_SEQ_RELU_EN
        if (wexp[NB-1]) wexp = '0;
`endif
        sbw.push_back({9{wexp}});
        start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        budget = 0;
        while ((busy_w || sbw.size() != 0) && budget < 200) begin @(negedge clk); budget++; end
        if (busy_w || sbw.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL wrap_timeout: got busy=%0d pending=%0d expected 0 0", busy_w, sbw.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_channel_seq.md
# conv_channel_seq

Multi-channel sequencer in front of the `conv_standard` engine. It accepts NCH (5x5 input map, 3x3 weight) pairs one at a time over a valid/ready handshake. For each pair it drives the engine's start pulse and waits for the engine's `data_valid`. It sums the 3x3 partial outputs element-wise into a wider accumulator and presents one 3x3 output map per job, so a single engine instance can serve multi-channel convolution layers.

## Interface
- `NCH`, default 3: input channels accumulated per job (1..255).
- `ACCW`, default NBITS+8: accumulator and output element width (two's complement). Must be at least NBITS.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin a job. Sampled only in IDLE.
- `map_valid`, in, 1: requester has a channel pair on `map_in`/`w_in`.
- `map_ready`, out, 1: sequencer accepts a pair this cycle.
- `map_in`, in, param25: 5x5 input map, NBITS per element.
- `w_in`, in, param9: 3x3 weights, NBITS per element.
- `conv_start`, out, 1: one-cycle start pulse to the engine.
- `conv_inputMAP`, out, param25: registered map to the engine.
- `conv_weights`, out, param9: registered weights to the engine.
- `conv_outputMAP`, in, param9: engine 3x3 result.
- `conv_data_valid`, in, 1: engine result valid.
- `out_map`, out, 9 x ACCW: accumulated 3x3 result.
- `out_valid`, out, 1: one-cycle pulse when `out_map` is final.
- `busy`, out, 1: high in any state other than IDLE.
- `chan_idx`, out, 8: index of the channel currently loaded or in flight.

## Operation
- FSM states: IDLE, LOAD, FIRE, WAIT, DONE.
- **IDLE**
  - `start`=1: clear all 9 accumulators and `chan_idx`, then go to LOAD.
  - Otherwise: hold `out_map`.
- **LOAD**
  - `map_ready`=1.
  - On `map_valid`&&`map_ready`: register `map_in`→`conv_inputMAP` and `w_in`→`conv_weights`, then go to FIRE.
- **FIRE**
  - `conv_start`=1 for exactly this cycle, then go to WAIT.
- **WAIT**
  - Wait for `conv_data_valid`. On it: `acc[i] <= acc[i] + sext(conv_outputMAP[i])` for i=0..8.
  - If `chan_idx`==NCH-1, go to DONE. Otherwise increment `chan_idx` and go to LOAD.
- **DONE**
  - `out_valid`=1 for one cycle, with `out_map` = final accumulators. Then go to IDLE.
- **Arithmetic**
  - Engine outputs are sign-extended from NBITS to ACCW.
  - Addition wraps modulo 2^ACCW with no saturation.
- `conv_inputMAP`/`conv_weights` stay stable from FIRE until `conv_data_valid` is seen.
- `start` outside IDLE is ignored. It is not queued.
- `conv_data_valid` outside WAIT is ignored and does not change the accumulators.
- `map_valid` outside LOAD is not consumed (`map_ready`=0).

## Timing
- **Reset values**:
  - State IDLE.
  - `map_ready`, `conv_start`, `out_valid`, `busy` = 0.
  - `chan_idx`=0.
  - `out_map`, `conv_inputMAP`, `conv_weights` all elements = 0.
- **Reset mid-job**: aborts immediately and discards partial sums. The next cycle behaves as post-reset.
- `busy` goes high the cycle after `start` is sampled.
- **Per channel**: 1 cycle LOAD (if `map_valid` is already high), 1 cycle FIRE, then L+1 cycles of WAIT, where L is the engine latency. The block is independent of L.
- `out_valid` is asserted the cycle after the last `conv_data_valid` is sampled.
- `start` may be sampled again the cycle after `out_valid`.
- **Minimum job length**: NCH·(3+L)+1 cycles after `start`.
- If `conv_data_valid` is held high for several cycles, only the first cycle in WAIT is accumulated. The FSM leaves WAIT on that cycle.

## Configuration
- **`CONV_SEQ_RELU_EN`**
  - Defined: in DONE, each `out_map` element is registered as max(acc[i], 0), so negative sums appear as 0.
  - Undefined: `out_map` = raw signed accumulators.
  - Accumulation itself is identical in both builds.

## Test plan
- **Basic sum**: NCH=3, every map all 1, every weight all 1, engine model L=4. Required: 3 `conv_start` pulses; `out_valid` once; all 9 `out_map`=27.
- **Negative sum**: NCH=3, maps all -1, weights all 1. Required: `out_map`=-27 without `CONV_SEQ_RELU_EN`; `out_map`=0 with it.
- **Backpressure**: `map_valid` withheld 5 cycles before channel 1. Required: FSM stays in LOAD with `map_ready`=1 and no `conv_start`; the final result is unchanged.
- **Spurious inputs**: `start` pulsed during WAIT, and `conv_data_valid` pulsed in LOAD. Required: no new job starts; accumulators are unaffected; result still 27.
- **Abort**: `reset` asserted in WAIT of channel 1. Required: next cycle `busy`=0 and `out_map`=0. A fresh job then yields 27.
- **Wrap**: ACCW=NBITS, with engine outputs 2^(NBITS-1)-1 on two channels (NCH=2). Required: `out_map`=-2, i.e. modulo wrap with no saturation.
